// File: rtl/mdl_busrespfe.sv
// mdl_busrespfe: 68000-style asynchronous bus target; syncs host strobes, issues one register
// strobe per bus cycle and closes it with DTACK_n.
module mdl_busrespfe #(
  parameter int ADDR_W   = 4,
  parameter int WAIT_CYC = 2
) (
  input  logic              i_MCLK,
  input  logic              i_RST_n,
  input  logic              i_CLK4M_PCEN_n,
  input  logic              i_CS_n,
  input  logic              i_AS_n,
  input  logic              i_UDS_n,
  input  logic              i_LDS_n,
  input  logic              i_R_nW,
  input  logic [ADDR_W-1:0] i_ADDR,
  input  logic [15:0]       i_DIN,
  output logic [15:0]       o_DOUT,
  output logic              o_DOUT_OE,
  output logic              o_DTACK_n,
  output logic [ADDR_W-1:0] o_REG_ADDR,
  output logic [1:0]        o_REG_BE,
  output logic [15:0]       o_REG_WDATA,
  output logic              o_REG_RD,
  output logic              o_REG_WR,
  input  logic              i_REG_BUSY,
  input  logic [15:0]       i_REG_RDATA
);
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_RELEASE} state_t;
  state_t state, state_d;
  logic [1:0] cs_s, as_s, uds_s, lds_s;
  logic [3:0] cnt;
  logic rd_cyc, tick, req, as_high, accept;
  assign tick    = ~i_CLK4M_PCEN_n;
  assign as_high = as_s[1];
  assign req     = ~cs_s[1] & ~as_s[1] & (~uds_s[1] | ~lds_s[1]);
  assign accept  = tick && state == S_IDLE && req;
  always_comb begin
    state_d = state;
    if (tick)
      case (state)
        S_IDLE:    state_d = req ? S_DECODE : S_IDLE;
        S_DECODE:  state_d = as_high ? S_IDLE : (WAIT_CYC != 0) ? S_WAIT : !i_REG_BUSY ? S_ACK : S_DECODE;
        // the count is compared as if already decremented, so ACK lands WAIT_CYC ticks after DECODE
        S_WAIT:    state_d = as_high ? S_IDLE : (cnt <= 4'd1 && !i_REG_BUSY) ? S_ACK : S_WAIT;
        S_ACK:     state_d = as_high ? S_RELEASE : S_ACK;
        S_RELEASE: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
  end
  always_ff @(posedge i_MCLK or negedge i_RST_n)
    if (!i_RST_n) state <= S_IDLE;
    else state <= state_d;
  always_ff @(posedge i_MCLK or negedge i_RST_n)
    if (!i_RST_n) begin
      cs_s        <= 2'b11;
      as_s        <= 2'b11;
      uds_s       <= 2'b11;
      lds_s       <= 2'b11;
      cnt         <= 4'd0;
      rd_cyc      <= 1'b0;
      o_REG_ADDR  <= '0;
      o_REG_BE    <= 2'b00;
      o_REG_WDATA <= 16'd0;
      o_REG_RD    <= 1'b0;
      o_REG_WR    <= 1'b0;
      o_DOUT      <= 16'd0;
    end else begin
      cs_s     <= {cs_s[0], i_CS_n};
      as_s     <= {as_s[0], i_AS_n};
      uds_s    <= {uds_s[0], i_UDS_n};
      lds_s    <= {lds_s[0], i_LDS_n};
      o_REG_RD <= accept && i_R_nW;
      o_REG_WR <= accept && !i_R_nW;
      if (accept) begin
        rd_cyc      <= i_R_nW;
        o_REG_ADDR  <= i_ADDR;
        o_REG_BE    <= {~uds_s[1], ~lds_s[1]};
        o_REG_WDATA <= i_DIN;
      end
      if (tick && state == S_DECODE) cnt <= 4'(WAIT_CYC);
      else if (tick && state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (tick && state != S_ACK && state_d == S_ACK && rd_cyc) o_DOUT <= i_REG_RDATA;
    end
  assign o_DTACK_n = state != S_ACK;
  assign o_DOUT_OE = state == S_ACK && rd_cyc;
endmodule

// File: tb/tb_mdl_busrespfe.sv
// tb_mdl_busrespfe: randomized bus cycles against a queue-based scoreboard of strobes and acks.
module tb_mdl_busrespfe;
  localparam int WAIT = 2;
  logic clk = 0, rst_n = 0, pcen_n = 1;
  logic cs_n = 1, as_n = 1, uds_n = 1, lds_n = 1, r_nw = 1, busy = 0;
  logic [3:0] addr = 0;
  logic [15:0] din = 0, rdata = 0;
  logic [15:0] dout, wdata;
  logic [3:0] reg_addr;
  logic [1:0] reg_be;
  logic dout_oe, dtack_n, reg_rd, reg_wr;
  int tick_cnt = 0, checks = 0, failures = 0, t0_mon = 0;
  typedef struct {bit wr; logic [3:0] addr; logic [1:0] be; logic [15:0] wdata;} stb_t;
  typedef struct {bit rd; logic [15:0] rdata; int lat;} ack_t;
  stb_t sq[$];
  ack_t aq[$];
  stb_t ms;
  ack_t ma;
  bit prev_stb = 0, prev_dt = 1, cur_rd = 0, stb;

  mdl_busrespfe #(.ADDR_W(4), .WAIT_CYC(WAIT)) dut (
    .i_MCLK(clk), .i_RST_n(rst_n), .i_CLK4M_PCEN_n(pcen_n), .i_CS_n(cs_n), .i_AS_n(as_n),
    .i_UDS_n(uds_n), .i_LDS_n(lds_n), .i_R_nW(r_nw), .i_ADDR(addr), .i_DIN(din),
    .o_DOUT(dout), .o_DOUT_OE(dout_oe), .o_DTACK_n(dtack_n), .o_REG_ADDR(reg_addr),
    .o_REG_BE(reg_be), .o_REG_WDATA(wdata), .o_REG_RD(reg_rd), .o_REG_WR(reg_wr),
    .i_REG_BUSY(busy), .i_REG_RDATA(rdata));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #2;
    pcen_n = ($urandom_range(0, 2) != 0);
  end
  always @(posedge clk) if (!pcen_n) tick_cnt <= tick_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: every strobe and every DTACK falling edge consumes one expectation
  always @(negedge clk)
    if (rst_n) begin
      stb = reg_rd | reg_wr;
      if (stb) begin
        chk("strobe_single", 64'(prev_stb), 64'd0);
        if (sq.size() == 0) chk("unexpected_strobe", 64'd1, 64'd0);
        else begin
          ms = sq.pop_front();
          chk("strobe_kind", 64'({reg_wr, reg_rd}), 64'({ms.wr, !ms.wr}));
          chk("reg_addr", 64'(reg_addr), 64'(ms.addr));
          chk("reg_be", 64'(reg_be), 64'(ms.be));
          chk("reg_wdata", 64'(wdata), 64'(ms.wdata));
          t0_mon = tick_cnt;
        end
      end
      if (!dtack_n && prev_dt) begin
        if (aq.size() == 0) chk("unexpected_dtack", 64'd1, 64'd0);
        else begin
          ma = aq.pop_front();
          cur_rd = ma.rd;
          chk("dtack_latency", 64'(tick_cnt - t0_mon), 64'(ma.lat));
          if (ma.rd) chk("dout", 64'(dout), 64'(ma.rdata));
        end
      end
      if (!dtack_n) chk("dout_oe", 64'(dout_oe), 64'(cur_rd));
      prev_stb = stb;
      prev_dt = dtack_n;
    end else begin
      prev_stb = 0;
      prev_dt = 1;
    end

  task automatic release_bus();
    cs_n = 1; as_n = 1; uds_n = 1; lds_n = 1;
  endtask

  task automatic cycle(input bit rd, input logic [3:0] a, input logic [1:0] be, input logic [15:0] d,
                       input logic [15:0] rv, input int nb, input int hold, input bit abort, input bit ds_first);
    stb_t s;
    ack_t k;
    int t0;
    bit got;
    @(negedge clk);
    addr = a; r_nw = rd; din = d; rdata = rv;
    s.wr = !rd; s.addr = a; s.be = be; s.wdata = d;
    sq.push_back(s);
    if (!abort) begin
      k.rd = rd; k.rdata = rv; k.lat = 1 + WAIT + nb;
      aq.push_back(k);
    end
    cs_n = 0; as_n = 0; uds_n = !be[1]; lds_n = !be[0];
    got = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      got = reg_rd | reg_wr;
    end
    if (!got) begin
      chk("strobe_timeout", 64'd0, 64'd1);
      release_bus();
      return;
    end
    t0 = tick_cnt;
    busy = (nb > 0);
    if (abort) begin
      release_bus();
      busy = 0;
      repeat (60) @(negedge clk);
      chk("abort_no_dtack", 64'(dtack_n), 64'd1);
      return;
    end
    for (int i = 0; i < 1000 && tick_cnt - t0 < WAIT + nb; i++) @(negedge clk);
    busy = 0;
    got = !dtack_n;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      got = !dtack_n;
    end
    if (!got) chk("dtack_timeout", 64'd0, 64'd1);
    if (ds_first) begin
      uds_n = 1;
      lds_n = 1;
    end
    t0 = tick_cnt;
    for (int i = 0; i < 1000 && tick_cnt - t0 < hold; i++) @(negedge clk);
    if (ds_first) chk("ds_release_keeps_ack", 64'(dtack_n), 64'd0);
    release_bus();
    got = dtack_n;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      got = dtack_n;
    end
    if (!got) chk("release_timeout", 64'd0, 64'd1);
    chk("release_oe", 64'(dout_oe), 64'd0);
    if (rd) chk("dout_hold", 64'(dout), 64'(rv));
    busy = 1'($urandom_range(0, 1));
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  task automatic reset_in_ack();
    bit got;
    cycle_start(16'h7E57);
    got = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      got = !dtack_n;
    end
    if (!got) chk("rst_dtack_timeout", 64'd0, 64'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_async_outputs", 64'({dtack_n, dout_oe, reg_rd, reg_wr}), 64'(4'b1000));
    chk("rst_async_dout", 64'(dout), 64'd0);
    release_bus();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic cycle_start(input logic [15:0] rv);
    stb_t s;
    ack_t k;
    @(negedge clk);
    addr = 4'd6; r_nw = 1; din = 16'h0; rdata = rv; busy = 0;
    s.wr = 0; s.addr = 4'd6; s.be = 2'b11; s.wdata = 16'h0;
    sq.push_back(s);
    k.rd = 1; k.rdata = rv; k.lat = 1 + WAIT;
    aq.push_back(k);
    cs_n = 0; as_n = 0; uds_n = 0; lds_n = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({dtack_n, dout_oe, reg_rd, reg_wr, dout, reg_addr, reg_be, wdata}),
        64'({1'b1, 41'd0}));
    rst_n = 1;
    repeat (2) @(negedge clk);
    cycle(1, 4'd3, 2'b11, 16'h0000, 16'h1234, 0, 3, 0, 0);
    cycle(0, 4'd5, 2'b10, 16'hA55A, 16'h0000, 0, 2, 0, 0);
    cycle(1, 4'd7, 2'b01, 16'h0F0F, 16'hBEEF, 4, 1, 0, 0);
    cycle(1, 4'd2, 2'b11, 16'h1111, 16'hDEAD, 0, 0, 1, 0);
    cycle(1, 4'd9, 2'b11, 16'h2222, 16'hC0DE, 0, 10, 0, 0);
    cycle(1, 4'd10, 2'b11, 16'h3333, 16'h4321, 0, 0, 0, 0);
    cycle(0, 4'd15, 2'b01, 16'h5A5A, 16'h0000, 1, 4, 0, 1);
    reset_in_ack();
    cycle(1, 4'd1, 2'b11, 16'h4444, 16'h9876, 0, 1, 0, 0);
    for (int n = 0; n < 40; n++) begin
      logic [1:0] be;
      int hold;
      be = 2'($urandom_range(1, 3));
      hold = $urandom_range(0, 10);
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), be, 16'($urandom),
            16'($urandom), $urandom_range(0, 5), hold, $urandom_range(0, 5) == 0,
            hold >= 2 && $urandom_range(0, 2) == 0);
    end
    repeat (20) @(negedge clk);
    chk("queues_empty", 64'(sq.size() + aq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
